// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_onehot_arbiter_if;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output rel,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// 8-way round-robin arbiter, registered one-hot + index grant.
// A hold limit revokes a grant held for MAX_HOLD cycles (0 = no limit).
module rr_onehot_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    rr_onehot_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic             armed_q;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;

    logic             found;
    logic [2:0]       cand;
    logic [2:0]       win;
    logic             rev;

    // Winner: first requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        cand  = ptr_q;
        win   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next state: owner release/withdraw beats the hold limit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        rev     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // first edge after reset only settles; arbitration starts next
                if (armed_q && found) begin
                    state_d = GRANT;
                    idx_d   = win;
                    grant_d = 8'd1 << win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (bus.rel || !bus.req[idx_q]) begin
                    rev = 1'b1;
                end else if (HOLD_EN && cnt_q == HOLD_LAST) begin
                    rev  = 1'b1;
                    to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (rev) begin
                    state_d = IDLE;
                    grant_d = 8'h00;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                end
            end
        endcase
    end

    // State and output registers; reset clears outputs at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
            grant_q <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = to_q;
endmodule
